pc_redirect_unit: RTL and testbench

Fetch-side consumer of the PCSrc branch/jump decision. It holds the program counter and computes the next PC (sequential, redirect or hold), and it drives the IF/ID and ID/EX flush strobes. It sits between the execute-stage PCSrc decode and the instruction memory address port. It also detects misaligned redirect targets, enters a sticky trap state on one, and keeps a saturating count of taken redirects.

---
 rtl/pc_redirect_unit.sv | 128 ++++++++++++
 tb/tb_pc_redirect_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with branch/jump redirect, stall hold,
// misaligned-target trap and saturating redirect counter.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   PCSrc, PCTarget taken redirect and its target from execute
//   Stall           fetch hold from the hazard unit
//   PC, PCPlus4     current fetch address and its sequential successor
//   FetchValid      PC is a real fetch
//   FlushD, FlushE  clear IF/ID and ID/EX at the next edge
//   Trap, TrapPC    sticky misaligned-target flag and captured target
//   RedirectCount   accepted redirects, saturating
module pc_redirect_unit #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'hBFC00000,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCSrc,
    input  logic [WIDTH-1:0] PCTarget,
    input  logic             Stall,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlus4,
    output logic             FetchValid,
    output logic             FlushD,
    output logic             FlushE,
    output logic             Trap,
    output logic [WIDTH-1:0] TrapPC,
    output logic [CNT_W-1:0] RedirectCount
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        TRAP
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pc_n;
    logic [WIDTH-1:0] tpc_n;
    logic [CNT_W-1:0] cnt_n;
    logic             fv_n;
    logic             trap_n;
    logic             flush;
    logic             bad;
    logic             good;
    logic             hold;

    assign PCPlus4 = PC + WIDTH'(4);

    // Mutually exclusive RUN conditions; redirect outranks stall.
    assign bad  = PCSrc && (PCTarget[1:0] != 2'b00);
    assign good = PCSrc && (PCTarget[1:0] == 2'b00);
    assign hold = Stall && !PCSrc;

    always_comb begin
        state_n = state;
        pc_n    = PC;
        fv_n    = FetchValid;
        trap_n  = Trap;
        tpc_n   = TrapPC;
        cnt_n   = RedirectCount;
        flush   = 1'b0;
        unique case (state)
            BOOT: begin
                state_n = RUN;
                fv_n    = 1'b1;
            end
            RUN: begin
                fv_n = 1'b1;
                unique case (1'b1)
                    bad: begin
                        state_n = TRAP;
                        trap_n  = 1'b1;
                        tpc_n   = PCTarget;
                        fv_n    = 1'b0;
                        flush   = 1'b1;
                    end
                    good: begin
                        pc_n  = PCTarget;
                        flush = 1'b1;
                        if (RedirectCount != {CNT_W{1'b1}})
                            cnt_n = RedirectCount + CNT_W'(1);
                    end
                    hold: begin
                        pc_n = PC;
                    end
                    default: begin
                        pc_n = PCPlus4;
                    end
                endcase
            end
            TRAP: begin
                fv_n   = 1'b0;
                trap_n = 1'b1;
                flush  = 1'b1;
            end
            default: begin
                state_n = BOOT;
                fv_n    = 1'b0;
            end
        endcase
    end

    // Flushes are suppressed while reset is held, whatever the state.
    assign FlushD = flush && !rst;
    assign FlushE = flush && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BOOT;
            PC            <= RESET_PC;
            FetchValid    <= 1'b0;
            Trap          <= 1'b0;
            TrapPC        <= '0;
            RedirectCount <= '0;
        end else begin
            state         <= state_n;
            PC            <= pc_n;
            FetchValid    <= fv_n;
            Trap          <= trap_n;
            TrapPC        <= tpc_n;
            RedirectCount <= cnt_n;
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed bench for pc_redirect_unit.
// Three instances: default, wrap-around reset PC, 2-bit counter.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;

    logic        a_src, a_stall;
    logic [31:0] a_tgt;
    logic [31:0] a_pc, a_pc4, a_tpc;
    logic        a_fv, a_fd, a_fe, a_trap;
    logic [15:0] a_cnt;

    logic        b_src, b_stall;
    logic [31:0] b_tgt;
    logic [31:0] b_pc, b_pc4, b_tpc;
    logic        b_fv, b_fd, b_fe, b_trap;
    logic [15:0] b_cnt;

    logic        c_src, c_stall;
    logic [31:0] c_tgt;
    logic [31:0] c_pc, c_pc4, c_tpc;
    logic        c_fv, c_fd, c_fe, c_trap;
    logic [1:0]  c_cnt;

    logic [31:0] c_tgts [5];
    logic [31:0] c_exp  [5];

    always #5 clk = ~clk;

    pc_redirect_unit dut_a (
        .clk(clk), .rst(rst), .PCSrc(a_src), .PCTarget(a_tgt),
        .Stall(a_stall), .PC(a_pc), .PCPlus4(a_pc4),
        .FetchValid(a_fv), .FlushD(a_fd), .FlushE(a_fe),
        .Trap(a_trap), .TrapPC(a_tpc), .RedirectCount(a_cnt)
    );

    pc_redirect_unit #(.RESET_PC(32'hFFFFFFF8)) dut_b (
        .clk(clk), .rst(rst), .PCSrc(b_src), .PCTarget(b_tgt),
        .Stall(b_stall), .PC(b_pc), .PCPlus4(b_pc4),
        .FetchValid(b_fv), .FlushD(b_fd), .FlushE(b_fe),
        .Trap(b_trap), .TrapPC(b_tpc), .RedirectCount(b_cnt)
    );

    pc_redirect_unit #(.CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .PCSrc(c_src), .PCTarget(c_tgt),
        .Stall(c_stall), .PC(c_pc), .PCPlus4(c_pc4),
        .FetchValid(c_fv), .FlushD(c_fd), .FlushE(c_fe),
        .Trap(c_trap), .TrapPC(c_tpc), .RedirectCount(c_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        c_tgts[0] = 32'h00001000; c_exp[0] = 32'd1;
        c_tgts[1] = 32'h00002000; c_exp[1] = 32'd2;
        c_tgts[2] = 32'h00003000; c_exp[2] = 32'd3;
        c_tgts[3] = 32'h00004000; c_exp[3] = 32'd3;
        c_tgts[4] = 32'h00005000; c_exp[4] = 32'd3;

        rst = 1'b1;
        a_src = 1'b1; a_tgt = 32'hBFC00102; a_stall = 1'b1;
        b_src = 1'b0; b_tgt = '0; b_stall = 1'b0;
        c_src = 1'b0; c_tgt = '0; c_stall = 1'b0;

        // reset held two cycles with a bad redirect presented
        tick(); tick();
        chk("rst_pc", a_pc, 32'hBFC00000);
        chk("rst_fv", {31'b0, a_fv}, 32'd0);
        chk("rst_trap", {31'b0, a_trap}, 32'd0);
        chk("rst_tpc", a_tpc, 32'd0);
        chk("rst_cnt", {16'b0, a_cnt}, 32'd0);
        chk("rst_fd", {31'b0, a_fd}, 32'd0);
        chk("rst_fe", {31'b0, a_fe}, 32'd0);

        // BOOT cycle ignores PCSrc/Stall
        rst = 1'b0;
        #1;
        chk("boot_pc", a_pc, 32'hBFC00000);
        chk("boot_fv", {31'b0, a_fv}, 32'd0);
        chk("boot_fd", {31'b0, a_fd}, 32'd0);
        chk("boot_fe", {31'b0, a_fe}, 32'd0);
        chk("b_boot_pc", b_pc, 32'hFFFFFFF8);

        tick();
        a_src = 1'b0; a_stall = 1'b0;
        #1;
        chk("run0_pc", a_pc, 32'hBFC00000);
        chk("run0_fv", {31'b0, a_fv}, 32'd1);
        chk("run0_trap", {31'b0, a_trap}, 32'd0);
        chk("run0_cnt", {16'b0, a_cnt}, 32'd0);
        chk("run0_fd", {31'b0, a_fd}, 32'd0);
        chk("run0_pc4", a_pc4, 32'hBFC00004);
        chk("b_run0_pc", b_pc, 32'hFFFFFFF8);

        tick();
        chk("run1_pc", a_pc, 32'hBFC00004);
        chk("b_run1_pc", b_pc, 32'hFFFFFFFC);
        chk("b_wrap_pc4", b_pc4, 32'h00000000);
        tick();
        chk("run2_pc", a_pc, 32'hBFC00008);
        chk("run2_fv", {31'b0, a_fv}, 32'd1);
        chk("b_wrap_pc", b_pc, 32'h00000000);
        tick();
        tick();
        chk("run4_pc", a_pc, 32'hBFC00010);

        // good redirect
        a_src = 1'b1; a_tgt = 32'hBFC00100;
        #1;
        chk("redir_fd", {31'b0, a_fd}, 32'd1);
        chk("redir_fe", {31'b0, a_fe}, 32'd1);
        tick();
        a_src = 1'b0;
        #1;
        chk("redir_pc", a_pc, 32'hBFC00100);
        chk("redir_cnt", {16'b0, a_cnt}, 32'd1);
        chk("redir_fd_clr", {31'b0, a_fd}, 32'd0);
        tick();
        chk("redir_pc2", a_pc, 32'hBFC00104);

        // stall for three cycles at BFC00020
        a_src = 1'b1; a_tgt = 32'hBFC00020;
        tick();
        a_src = 1'b0; a_stall = 1'b1;
        #1;
        chk("stall0_pc", a_pc, 32'hBFC00020);
        chk("stall_cnt", {16'b0, a_cnt}, 32'd2);
        chk("stall_fd", {31'b0, a_fd}, 32'd0);
        tick();
        chk("stall1_pc", a_pc, 32'hBFC00020);
        tick();
        chk("stall2_pc", a_pc, 32'hBFC00020);
        a_stall = 1'b0;
        tick();
        chk("stall_rel_pc", a_pc, 32'hBFC00024);

        // redirect overrides stall
        a_stall = 1'b1; a_src = 1'b1; a_tgt = 32'hBFC00200;
        #1;
        chk("ovr_fd", {31'b0, a_fd}, 32'd1);
        chk("ovr_fe", {31'b0, a_fe}, 32'd1);
        tick();
        a_stall = 1'b0; a_src = 1'b0;
        #1;
        chk("ovr_pc", a_pc, 32'hBFC00200);
        chk("ovr_cnt", {16'b0, a_cnt}, 32'd3);

        // misaligned target enters TRAP
        a_src = 1'b1; a_tgt = 32'hBFC00102;
        #1;
        chk("bad_fe", {31'b0, a_fe}, 32'd1);
        tick();
        a_src = 1'b0;
        #1;
        chk("trap_flag", {31'b0, a_trap}, 32'd1);
        chk("trap_tpc", a_tpc, 32'hBFC00102);
        chk("trap_pc", a_pc, 32'hBFC00200);
        chk("trap_fv", {31'b0, a_fv}, 32'd0);
        chk("trap_fd", {31'b0, a_fd}, 32'd1);
        chk("trap_fe", {31'b0, a_fe}, 32'd1);
        chk("trap_cnt", {16'b0, a_cnt}, 32'd3);
        chk("trap_pc4", a_pc4, 32'hBFC00204);

        // TRAP ignores further redirects
        a_src = 1'b1; a_tgt = 32'hBFC00300;
        tick();
        chk("trap2_pc", a_pc, 32'hBFC00200);
        chk("trap2_tpc", a_tpc, 32'hBFC00102);
        chk("trap2_cnt", {16'b0, a_cnt}, 32'd3);
        chk("trap2_flag", {31'b0, a_trap}, 32'd1);

        // one-cycle reset leaves TRAP
        rst = 1'b1;
        #1;
        chk("rst2_fd", {31'b0, a_fd}, 32'd0);
        tick();
        rst = 1'b0; a_src = 1'b0;
        #1;
        chk("rst2_pc", a_pc, 32'hBFC00000);
        chk("rst2_trap", {31'b0, a_trap}, 32'd0);
        chk("rst2_tpc", a_tpc, 32'd0);
        chk("rst2_fv", {31'b0, a_fv}, 32'd0);
        chk("rst2_cnt", {16'b0, a_cnt}, 32'd0);
        tick();
        chk("rst2_run_fv", {31'b0, a_fv}, 32'd1);
        chk("rst2_run_pc", a_pc, 32'hBFC00000);

        // 2-bit counter saturates across consecutive redirects
        for (int i = 0; i < 5; i++) begin
            c_src = 1'b1; c_tgt = c_tgts[i];
            tick();
            chk("sat_pc", c_pc, c_tgts[i]);
            chk("sat_cnt", {30'b0, c_cnt}, c_exp[i]);
        end
        c_src = 1'b0;
        tick();
        chk("sat_seq_pc", c_pc, 32'h00005004);
        chk("sat_hold_cnt", {30'b0, c_cnt}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
